// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared types, opcodes and frame check for the UART frame controller.
package uart_frame_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_CMD, WAIT_DATA, WAIT_CHK} state_t;
    typedef enum logic [1:0] {ERR_NONE, ERR_CHK, ERR_CMD, ERR_TMO} err_t;

    localparam logic [1:0] OP_LO  = 2'd0;
    localparam logic [1:0] OP_HI  = 2'd1;
    localparam logic [1:0] OP_LED = 2'd2;
    localparam logic [1:0] OP_CLR = 2'd3;

    localparam logic [7:0] DEF_SYNC_BYTE    = 8'hA5;
    localparam int         DEF_TIMEOUT_CLKS = 43400;

    // Checksum failure outranks an unknown command.
    function automatic err_t check_frame(input logic [7:0] cmd, input logic [7:0] data,
                                         input logic [7:0] chk);
        return (chk != (cmd ^ data)) ? ERR_CHK : (cmd[7:2] != 6'd0) ? ERR_CMD : ERR_NONE;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// frame_timer: inter-byte timeout down-counter; expired flags the last clock before a timeout.
module frame_timer #(
    parameter int TIMEOUT_CLKS = 43400
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CLKS);
    localparam logic [W-1:0] LOAD = W'(TIMEOUT_CLKS - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= LOAD;
        else if (clear)
            cnt <= LOAD;
        else if (run && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = run && cnt == '0;

endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: parses [SYNC][CMD][DATA][CHK] frames from the UART byte stream and
// applies them to the display/LED registers, with timeout resync and error reporting.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE,
    parameter int         TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [15:0] disp_word,
    output logic [3:0]  leds,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [7:0]  err_count
);

    state_t      state, state_nx;
    logic [7:0]  cmd, data;
    logic        expired, tmo, eval, ok_nx, err_nx;
    err_t        chk_err, code_nx;
    logic [15:0] disp_nx;
    logic [3:0]  leds_nx;

    // The timer sits at its reload value in IDLE and restarts on every accepted byte.
    frame_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (rx_valid || state == IDLE),
        .run     (state != IDLE),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (rx_valid) begin
            case (state)
                IDLE:      state_nx = (rx_data == SYNC_BYTE) ? WAIT_CMD : IDLE;
                WAIT_CMD:  state_nx = (rx_data == SYNC_BYTE) ? WAIT_CMD : WAIT_DATA;
                WAIT_DATA: state_nx = WAIT_CHK;
                WAIT_CHK:  state_nx = IDLE;
            endcase
        end else if (tmo) begin
            state_nx = IDLE;
        end
    end

    always_comb begin
        tmo     = expired && !rx_valid;
        eval    = rx_valid && state == WAIT_CHK;
        chk_err = check_frame(cmd, data, rx_data);
        ok_nx   = eval && chk_err == ERR_NONE;
        err_nx  = (eval && chk_err != ERR_NONE) || tmo;
        code_nx = tmo ? ERR_TMO : chk_err;
        disp_nx = disp_word;
        leds_nx = leds;
        if (ok_nx) begin
            case (cmd[1:0])
                OP_LO:  disp_nx[7:0]  = data;
                OP_HI:  disp_nx[15:8] = data;
                OP_LED: leds_nx       = data[3:0];
                OP_CLR: begin
                    disp_nx = '0;
                    leds_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd       <= '0;
            data      <= '0;
            disp_word <= '0;
            leds      <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            err_count <= '0;
        end else begin
            if (rx_valid && state == WAIT_CMD && rx_data != SYNC_BYTE)
                cmd <= rx_data;
            if (rx_valid && state == WAIT_DATA)
                data <= rx_data;
            disp_word <= disp_nx;
            leds      <= leds_nx;
            frame_ok  <= ok_nx;
            frame_err <= err_nx;
            if (ok_nx)
                err_code <= ERR_NONE;
            else if (err_nx)
                err_code <= code_nx;
            if (err_nx && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: scoreboard bench; a frame model pushes the expected pulse, code,
// registers and arrival cycle, and a negedge monitor pops and compares on each pulse.
module tb_uart_frame_ctrl;

    localparam int TMO = 100;
    localparam int GAP = 8;

    typedef struct {
        logic [1:0]  kind;
        logic [1:0]  code;
        logic [15:0] disp;
        logic [3:0]  leds;
        logic [7:0]  cnt;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic [15:0] disp_word;
    logic [3:0]  leds;
    logic        frame_ok, frame_err;
    logic [1:0]  err_code;
    logic [7:0]  err_count;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_drv = 0;
    exp_t sb[$];
    exp_t pend;
    exp_t got;

    logic [15:0] m_disp = '0;
    logic [3:0]  m_leds = '0;
    logic [7:0]  m_cnt = '0;

    uart_frame_ctrl #(.SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .disp_word (disp_word),
        .leds      (leds),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .err_count (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, req, cyc);
        end
    endtask

    task automatic model_err(input logic [1:0] code);
        m_cnt = (m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1;
        pend.kind = 2'b01;
        pend.code = code;
    endtask

    task automatic model(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
        if (k != (c ^ d))
            model_err(2'd1);
        else if (c[7:2] != 6'd0)
            model_err(2'd2);
        else begin
            if (c[1:0] == 2'd0) m_disp[7:0] = d;
            if (c[1:0] == 2'd1) m_disp[15:8] = d;
            if (c[1:0] == 2'd2) m_leds = d[3:0];
            if (c[1:0] == 2'd3) begin
                m_disp = '0;
                m_leds = '0;
            end
            pend.kind = 2'b10;
            pend.code = 2'd0;
        end
        pend.disp = m_disp;
        pend.leds = m_leds;
        pend.cnt  = m_cnt;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit push, input int gap);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        last_drv = cyc;
        if (push) begin
            pend.cyc = cyc + 1;
            sb.push_back(pend);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'hXX;
        repeat (gap) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
        send_byte(8'hA5, 0, GAP);
        send_byte(c, 0, GAP);
        send_byte(d, 0, GAP);
        model(c, d, k);
        send_byte(k, 1, GAP);
    endtask

    always @(negedge clk) begin
        if (rst_n && (frame_ok || frame_err)) begin
            if (sb.size() == 0) begin
                chk("spurious_pulse", {30'd0, frame_ok, frame_err}, 32'd0);
            end else begin
                got = sb.pop_front();
                chk("pulse_kind", {30'd0, frame_ok, frame_err}, {30'd0, got.kind});
                chk("err_code", {30'd0, err_code}, {30'd0, got.code});
                chk("disp_word", {16'd0, disp_word}, {16'd0, got.disp});
                chk("leds", {28'd0, leds}, {28'd0, got.leds});
                chk("err_count", {24'd0, err_count}, {24'd0, got.cnt});
                chk("pulse_cycle", cyc, got.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, queue=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_disp", {16'd0, disp_word}, 32'd0);
        chk("rst_leds", {28'd0, leds}, 32'd0);
        chk("rst_pulses", {30'd0, frame_ok, frame_err}, 32'd0);
        chk("rst_code", {30'd0, err_code}, 32'd0);
        chk("rst_count", {24'd0, err_count}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        frame(8'h00, 8'h3C, 8'h3C);
        frame(8'h03, 8'h00, 8'h03);
        frame(8'h01, 8'h12, 8'h13);
        frame(8'h02, 8'h0F, 8'h0D);
        frame(8'h00, 8'h3C, 8'h3D);
        repeat (5) @(negedge clk);
        chk("code_held", {30'd0, err_code}, 32'd1);
        frame(8'h40, 8'h00, 8'h40);

        send_byte(8'h11, 0, GAP);
        send_byte(8'h22, 0, GAP);
        send_byte(8'hA5, 0, GAP);
        frame(8'h03, 8'h00, 8'h03);

        send_byte(8'hA5, 0, GAP);
        send_byte(8'h01, 0, GAP);
        model_err(2'd3);
        pend.disp = m_disp;
        pend.leds = m_leds;
        pend.cnt  = m_cnt;
        pend.cyc  = last_drv + 1 + TMO;
        sb.push_back(pend);
        repeat (TMO + 10) @(negedge clk);
        chk("tmo_drained", sb.size(), 32'd0);

        // Data byte lands exactly on the expiry cycle, so it must be taken instead.
        send_byte(8'hA5, 0, GAP);
        send_byte(8'h01, 0, TMO - 2);
        send_byte(8'h34, 0, GAP);
        model(8'h01, 8'h34, 8'h35);
        send_byte(8'h35, 1, GAP);
        repeat (TMO + 10) @(negedge clk);

        for (int i = 0; i < 300; i++)
            frame(8'h00, 8'h00, 8'h01);
        repeat (5) @(negedge clk);
        chk("sat_count", {24'd0, err_count}, 32'hFF);

        send_byte(8'hA5, 0, GAP);
        send_byte(8'h00, 0, 2);
        rst_n = 1'b0;
        #1;
        m_disp = '0;
        m_leds = '0;
        m_cnt  = '0;
        chk("midrst_disp", {16'd0, disp_word}, 32'd0);
        chk("midrst_leds", {28'd0, leds}, 32'd0);
        chk("midrst_count", {24'd0, err_count}, 32'd0);
        chk("midrst_code", {30'd0, err_code}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frame(8'h01, 8'h5A, 8'h5B);
        repeat (TMO + 10) @(negedge clk);

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
